// File: rtl/gray_sched_pkg.sv
// Shared types and sizing helpers for the Gray-decode scheduler.
// Imported by the arbiter and the top-level scheduler.
package gray_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_WIDTH = 4;

    // Requester-index width; a single requester still needs one bit.
    function automatic int id_width(input int n_req);
        return (n_req <= 1) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts at ptr and walks
// upward, wrapping modulo N_REQ; the first asserted request wins.
module rr_arbiter
    import gray_sched_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int ID_W  = id_width(DEFAULT_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // One extra bit so ptr + i never wraps before the modulo step.
            sum = {1'b0, ptr} + (ID_W + 1)'(i);
            if (sum >= (ID_W + 1)'(N_REQ)) begin
                sum = sum - (ID_W + 1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/gray_decode_scheduler.sv
// Round-robin scheduler sharing one registered Gray-to-binary decode stage
// among N_REQ requesters, with a single tagged valid/ready response port.
module gray_decode_scheduler
    import gray_sched_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int ID_W = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_gray,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_gray,
    output logic [WIDTH-1:0]       rsp_binary,
    output logic                   busy
);

    state_t           state_reg, state_next;
    logic [ID_W-1:0]  ptr_reg;
    logic [ID_W-1:0]  id_reg;
    logic [WIDTH-1:0] gray_reg;
    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] bin_next;
    logic             rsp_valid_reg;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             capture;
    logic             decode_en;
    logic             rsp_done;

    logic [WIDTH-1:0] gray_word [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign gray_word[gi] = req_gray[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arbiter (
        .req      (req_valid),
        .ptr      (ptr_reg),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // req_ready is gated by rst_n so nothing appears accepted while in reset.
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        capture    = 1'b0;
        decode_en  = 1'b0;
        rsp_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = grant & {N_REQ{rst_n}};
                if (|grant) begin
                    capture    = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                decode_en  = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // MSB passes through; each lower bit folds in the running prefix XOR.
    always_comb begin
        bin_next = '0;
        bin_next[WIDTH-1] = gray_reg[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) begin
            bin_next[k] = bin_next[k+1] ^ gray_reg[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            id_reg        <= '0;
            gray_reg      <= '0;
            bin_reg       <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            if (capture) begin
                id_reg   <= grant_id;
                gray_reg <= gray_word[grant_id];
            end
            if (decode_en) begin
                bin_reg       <= bin_next;
                rsp_valid_reg <= 1'b1;
            end
            if (rsp_done) begin
                rsp_valid_reg <= 1'b0;
                ptr_reg <= (id_reg == ID_W'(N_REQ - 1)) ? '0 : id_reg + ID_W'(1);
            end
        end
    end

    assign rsp_valid  = rsp_valid_reg;
    assign rsp_id     = id_reg;
    assign rsp_gray   = gray_reg;
    assign rsp_binary = bin_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_gray_decode_scheduler.sv
// Directed bench for gray_decode_scheduler (N_REQ=4, WIDTH=4) with
// hand-computed expectations checked by immediate assertions.
module tb_gray_decode_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_gray;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_gray;
    logic [3:0]  rsp_binary;
    logic        busy;

    int n_checks;
    int n_fail;

    gray_decode_scheduler #(
        .N_REQ (4),
        .WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_gray   (req_gray),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_gray   (rsp_gray),
        .rsp_binary (rsp_binary),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_gray(input int idx, input logic [3:0] val);
        req_gray[idx*4 +: 4] = val;
    endtask

    int          id_tab  [5] = '{0, 1, 2, 3, 0};
    logic [3:0]  gray_tab[5] = '{4'b0000, 4'b0001, 4'b0011, 4'b1111, 4'b0000};
    logic [3:0]  bin_tab [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b1010, 4'b0000};

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_gray  = 16'h0;
        rsp_ready = 1'b0;

        // Reset state, including req_ready forced low with requests pending
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_gray", 32'(rsp_gray), 32'h0);
        chk("rst_rsp_binary", 32'(rsp_binary), 32'h0);
        req_valid = 4'b0000;
        cyc();
        cyc();
        rst_n = 1'b1;

        // Single request from requester 2
        set_gray(2, 4'b0110);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        chk("single_idle_busy", 32'(busy), 32'h0);
        cyc();
        req_valid = 4'b0000;
        #1;
        chk("single_decode_ready", 32'(req_ready), 32'h0);
        chk("single_decode_busy", 32'(busy), 32'h1);
        chk("single_decode_valid", 32'(rsp_valid), 32'h0);
        cyc();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_id", 32'(rsp_id), 32'h2);
        chk("single_rsp_gray", 32'(rsp_gray), 32'h6);
        chk("single_rsp_bin", 32'(rsp_binary), 32'h4);
        rsp_ready = 1'b1;
        cyc();
        chk("single_done_valid", 32'(rsp_valid), 32'h0);
        chk("single_done_busy", 32'(busy), 32'h0);

        // Reset pulse brings ptr back to 0
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;

        // All four continuously valid, rsp_ready held high
        for (int i = 0; i < 4; i++) set_gray(i, gray_tab[i]);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            #1;
            chk($sformatf("rr_ready_%0d", t), 32'(req_ready), 32'(1 << id_tab[t]));
            cyc();
            chk($sformatf("rr_decode_ready_%0d", t), 32'(req_ready), 32'h0);
            chk($sformatf("rr_decode_valid_%0d", t), 32'(rsp_valid), 32'h0);
            cyc();
            chk($sformatf("rr_valid_%0d", t), 32'(rsp_valid), 32'h1);
            chk($sformatf("rr_id_%0d", t), 32'(rsp_id), 32'(id_tab[t]));
            chk($sformatf("rr_gray_%0d", t), 32'(rsp_gray), 32'(gray_tab[t]));
            chk($sformatf("rr_bin_%0d", t), 32'(rsp_binary), 32'(bin_tab[t]));
            cyc();
        end

        // Fairness wrap: serve 3, then 0 and 3 both valid -> 0 wins
        req_valid = 4'b1000;
        #1;
        chk("wrap_ready_3", 32'(req_ready), 32'h8);
        cyc();
        req_valid = 4'b0000;
        cyc();
        chk("wrap_rsp_id_3", 32'(rsp_id), 32'h3);
        cyc();
        req_valid = 4'b1001;
        #1;
        chk("wrap_ready_0", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0000;
        cyc();
        chk("wrap_rsp_id_0", 32'(rsp_id), 32'h0);
        chk("wrap_rsp_bin_0", 32'(rsp_binary), 32'h0);
        cyc();
        rsp_ready = 1'b0;

        // Backpressure: requester 1 sends 1000, held for 5 cycles
        set_gray(1, 4'b1000);
        req_valid = 4'b0010;
        #1;
        chk("bp_ready", 32'(req_ready), 32'h2);
        cyc();
        req_valid = 4'b0000;
        cyc();
        req_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_valid_%0d", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp_id_%0d", i), 32'(rsp_id), 32'h1);
            chk($sformatf("bp_bin_%0d", i), 32'(rsp_binary), 32'hF);
            chk($sformatf("bp_ready_%0d", i), 32'(req_ready), 32'h0);
            chk($sformatf("bp_busy_%0d", i), 32'(busy), 32'h1);
            cyc();
        end
        // Release with requester 2 valid in the same cycle: not accepted yet
        rsp_ready = 1'b1;
        #1;
        chk("simul_ready_blocked", 32'(req_ready), 32'h0);
        cyc();
        rsp_ready = 1'b0;
        chk("bp_release_valid", 32'(rsp_valid), 32'h0);
        chk("simul_ready_next", 32'(req_ready), 32'h4);

        // Requester 2 (gray 0011) accepted; requester 1 pulses during RESP
        cyc();
        req_valid = 4'b0000;
        cyc();
        chk("wd_rsp_id", 32'(rsp_id), 32'h2);
        chk("wd_rsp_bin", 32'(rsp_binary), 32'h2);
        req_valid = 4'b0010;
        #1;
        chk("wd_pulse_ready", 32'(req_ready), 32'h0);
        cyc();
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wd_no_rsp_%0d", i), 32'(rsp_valid), 32'h0);
            chk($sformatf("wd_no_ready_%0d", i), 32'(req_ready), 32'h0);
            cyc();
        end
        rsp_ready = 1'b0;

        // Reset while in RESP discards the transaction
        req_valid = 4'b1000;
        #1;
        chk("rr3_ready", 32'(req_ready), 32'h8);
        cyc();
        req_valid = 4'b0000;
        cyc();
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_id", 32'(rsp_id), 32'h0);
        chk("mid_rst_bin", 32'(rsp_binary), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        cyc();
        req_valid = 4'b0000;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_no_stale", 32'(rsp_valid), 32'h0);
        req_valid = 4'b1010;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h2);
        cyc();
        req_valid = 4'b0000;
        cyc();
        chk("post_rst_rsp_id", 32'(rsp_id), 32'h1);
        chk("post_rst_rsp_bin", 32'(rsp_binary), 32'hF);
        rsp_ready = 1'b1;
        cyc();
        chk("post_rst_done", 32'(rsp_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
